// File: rtl/riscv_id_decode_stage.sv
// RV32/RV64 decode stage: field extraction, immediates, illegal detection; 1-cycle latency when empty.
// Registered output plus one skid entry; if_ready_o = !skid_valid, so full rate is sustained under stalls.
module riscv_id_decode_stage #(
  parameter int XLEN  = 32,
  parameter bit HAS_M = 1'b1,
  parameter bit HAS_A = 1'b0,
  parameter bit HAS_S = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            if_valid_i,
  output logic            if_ready_o,
  input  logic [31:0]     if_instr_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [31:0]     id_instr_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [4:0]      id_opcode_o,
  output logic [2:0]      id_func3_o,
  output logic [2:0]      id_unit_o,
  output logic [4:0]      id_rs1_o,
  output logic [4:0]      id_rs2_o,
  output logic [4:0]      id_rd_o,
  output logic [XLEN-1:0] id_imm_o,
  output logic            id_we_o,
  output logic            id_word_o,
  output logic            id_illegal_o,
  output logic [15:0]     illegal_cnt_o
);
  localparam bit RV64 = (XLEN == 64);

  localparam logic [4:0] OPC_LOAD   = 5'b00000, OPC_MISC  = 5'b00011, OPC_OPIMM  = 5'b00100,
                         OPC_AUIPC  = 5'b00101, OPC_OPIMM32 = 5'b00110, OPC_STORE = 5'b01000,
                         OPC_AMO    = 5'b01011, OPC_OP    = 5'b01100, OPC_LUI    = 5'b01101,
                         OPC_OP32   = 5'b01110, OPC_BRANCH = 5'b11000, OPC_JALR  = 5'b11001,
                         OPC_JAL    = 5'b11011, OPC_SYSTEM = 5'b11100;

  typedef enum logic [2:0] {
    U_ALU = 3'd0, U_BRANCH = 3'd1, U_LSU = 3'd2, U_MUL = 3'd3,
    U_DIV = 3'd4, U_AMO = 3'd5, U_SYS = 3'd6, U_NOP = 3'd7
  } unit_e;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [4:0]      opcode;
    logic [2:0]      func3;
    unit_e           unit;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            we;
    logic            word;
    logic            illegal;
  } beat_t;

  logic [31:0] ins;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm32;
  logic        ill, we, word, sys_ok, amo_ok;
  unit_e       unit;
  beat_t       dec;

  assign ins = if_instr_i;
  assign f3  = ins[14:12];
  assign f7  = ins[31:25];

  assign sys_ok = (ins inside {32'h0000_0073, 32'h0010_0073, 32'h3020_0073, 32'h1050_0073}) ||
                  (HAS_S && (ins == 32'h1020_0073 || (ins[31:20] == 12'h104 && ins[14:7] == 8'h00)));
  assign amo_ok = (ins[31:27] inside {5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h08, 5'h0C,
                                      5'h10, 5'h14, 5'h18, 5'h1C}) &&
                  !(ins[31:27] == 5'h02 && ins[24:20] != 5'd0);

  always_comb begin
    ill   = 1'b0;
    we    = 1'b1;
    word  = 1'b0;
    unit  = U_ALU;
    imm32 = '0;
    case (ins[6:2])
      OPC_LOAD: begin
        unit  = U_LSU;
        imm32 = {{20{ins[31]}}, ins[31:20]};
        ill   = (f3 == 3'b111) || (!RV64 && (f3 == 3'b011 || f3 == 3'b110));
      end
      OPC_STORE: begin
        unit  = U_LSU;
        we    = 1'b0;
        imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ill   = f3[2] || (f3 == 3'b011 && !RV64);
      end
      OPC_MISC: begin
        unit  = U_NOP;
        we    = 1'b0;
        imm32 = {{20{ins[31]}}, ins[31:20]};
        ill   = (f3[2:1] != 2'b00);
      end
      OPC_OPIMM: begin
        imm32 = {{20{ins[31]}}, ins[31:20]};
        // shamt bit 5 (instr[25]) only exists on RV64
        if (f3 == 3'b001)
          ill = (ins[31:26] != 6'b000000) || (!RV64 && ins[25]);
        else if (f3 == 3'b101)
          ill = !((ins[31:26] == 6'b000000 || ins[31:26] == 6'b010000) && (RV64 || !ins[25]));
      end
      OPC_OPIMM32: begin
        word  = 1'b1;
        imm32 = {{20{ins[31]}}, ins[31:20]};
        ill   = !RV64 || !((f3 == 3'b000) || (f3 == 3'b001 && f7 == 7'h00) ||
                           (f3 == 3'b101 && (f7 == 7'h00 || f7 == 7'h20)));
      end
      OPC_AUIPC, OPC_LUI: imm32 = {ins[31:12], 12'b0};
      OPC_OP, OPC_OP32: begin
        word = (ins[6:2] == OPC_OP32);
        case (f7)
          7'h00:   ill = word && !(f3 inside {3'b000, 3'b001, 3'b101});
          7'h20:   ill = !(f3 inside {3'b000, 3'b101});
          7'h01: begin
            ill  = !HAS_M || (word && (f3 inside {3'b001, 3'b010, 3'b011}));
            unit = f3[2] ? U_DIV : U_MUL;
          end
          default: ill = 1'b1;
        endcase
        if (word && !RV64) ill = 1'b1;
      end
      OPC_AMO: begin
        unit = U_AMO;
        ill  = !HAS_A || !amo_ok || !(f3 == 3'b010 || (f3 == 3'b011 && RV64));
      end
      OPC_BRANCH: begin
        unit  = U_BRANCH;
        we    = 1'b0;
        imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        ill   = (f3[2:1] == 2'b01);
      end
      OPC_JALR: begin
        unit  = U_BRANCH;
        imm32 = {{20{ins[31]}}, ins[31:20]};
        ill   = (f3 != 3'b000);
      end
      OPC_JAL: begin
        unit  = U_BRANCH;
        imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      OPC_SYSTEM: begin
        unit  = U_SYS;
        imm32 = {{20{ins[31]}}, ins[31:20]};
        we    = (f3 != 3'b000);
        ill   = (f3 == 3'b100) || (f3 == 3'b000 && !sys_ok);
      end
      default: ill = 1'b1;
    endcase
    if (ins[1:0] != 2'b11) ill = 1'b1;
    if (ins[11:7] == 5'd0) we = 1'b0;

    dec        = '0;
    dec.instr  = ins;
    dec.pc     = if_pc_i;
    dec.opcode = ins[6:2];
    dec.func3  = f3;
    dec.rs1    = ins[19:15];
    dec.rs2    = ins[24:20];
    dec.rd     = ins[11:7];
    if (ill) begin
      dec.unit    = U_SYS;
      dec.illegal = 1'b1;
    end else begin
      dec.unit     = unit;
      dec.we       = we;
      dec.word     = word;
      dec.imm      = {XLEN{imm32[31]}};
      dec.imm[31:0] = imm32;
    end
  end

  beat_t       out_q, out_d, skid_q, skid_d;
  logic        out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic [15:0] illegal_cnt_q, illegal_cnt_d;
  logic        in_fire, out_fire;

  assign in_fire  = if_valid_i && !skid_vld_q;
  assign out_fire = out_vld_q && id_ready_i;

  always_comb begin
    out_d         = out_q;
    out_vld_d     = out_vld_q;
    skid_d        = skid_q;
    skid_vld_d    = skid_vld_q;
    illegal_cnt_d = illegal_cnt_q;
    if (out_fire && out_q.illegal && illegal_cnt_q != 16'hFFFF)
      illegal_cnt_d = illegal_cnt_q + 16'd1;
    if (flush_i) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || id_ready_i) begin
      // skid holds the older beat; while it is full no new input is accepted
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d = in_fire;
        if (in_fire) out_d = dec;
      end
    end else if (in_fire) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q         <= '0;
      out_q.instr   <= 32'h0000_0013;
      skid_q        <= '0;
      out_vld_q     <= 1'b0;
      skid_vld_q    <= 1'b0;
      illegal_cnt_q <= '0;
    end else begin
      out_q         <= out_d;
      skid_q        <= skid_d;
      out_vld_q     <= out_vld_d;
      skid_vld_q    <= skid_vld_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign if_ready_o    = !skid_vld_q;
  assign id_valid_o    = out_vld_q;
  assign id_instr_o    = out_q.instr;
  assign id_pc_o       = out_q.pc;
  assign id_opcode_o   = out_q.opcode;
  assign id_func3_o    = out_q.func3;
  assign id_unit_o     = out_q.unit;
  assign id_rs1_o      = out_q.rs1;
  assign id_rs2_o      = out_q.rs2;
  assign id_rd_o       = out_q.rd;
  assign id_imm_o      = out_q.imm;
  assign id_we_o       = out_q.we;
  assign id_word_o     = out_q.word;
  assign id_illegal_o  = out_q.illegal;
  assign illegal_cnt_o = illegal_cnt_q;
endmodule

// File: tb/tb_riscv_id_decode_stage.sv
// Drives three decode-stage configurations (RV32+M, RV32 no M, RV64+M+A+S) with shared stimulus
// and checks them every cycle against a queue-based transaction model.
module tb_riscv_id_decode_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        vld = 1'b0;
  logic        id_rdy = 1'b1;
  logic [31:0] instr = 32'h0;
  logic [63:0] pc_in = 64'h0;
  logic [63:0] pc_next = 64'hFFFF_FFF0_8000_0000;

  logic        o_rdy[3], o_vld[3], o_we[3], o_word[3], o_ill[3];
  logic [31:0] o_instr[3];
  logic [63:0] o_pc[3], o_imm[3];
  logic [4:0]  o_opc[3], o_rs1[3], o_rs2[3], o_rd[3];
  logic [2:0]  o_f3[3], o_unit[3];
  logic [15:0] o_cnt[3];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int XL = (g == 2) ? 64 : 32;
    logic [XL-1:0] pc_o, imm_o;
    riscv_id_decode_stage #(.XLEN(XL), .HAS_M(g != 1), .HAS_A(g == 2), .HAS_S(g == 2)) u_dut (
      .clk(clk), .rst(rst), .flush_i(flush),
      .if_valid_i(vld), .if_ready_o(o_rdy[g]), .if_instr_i(instr), .if_pc_i(pc_in[XL-1:0]),
      .id_valid_o(o_vld[g]), .id_ready_i(id_rdy), .id_instr_o(o_instr[g]), .id_pc_o(pc_o),
      .id_opcode_o(o_opc[g]), .id_func3_o(o_f3[g]), .id_unit_o(o_unit[g]),
      .id_rs1_o(o_rs1[g]), .id_rs2_o(o_rs2[g]), .id_rd_o(o_rd[g]), .id_imm_o(imm_o),
      .id_we_o(o_we[g]), .id_word_o(o_word[g]), .id_illegal_o(o_ill[g]),
      .illegal_cnt_o(o_cnt[g]));
    assign o_pc[g]  = 64'(pc_o);
    assign o_imm[g] = 64'(imm_o);
  end

  typedef struct packed {
    logic [2:0]  unit;
    logic [63:0] imm;
    logic        we;
    logic        word;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] w;
    logic [63:0] pc;
  } txn_t;

  // Interpret the low n bits of v as a two's-complement number.
  function automatic logic [63:0] sx(input logic [31:0] v, input int n);
    longint x;
    x = longint'(v) & ((longint'(1) << n) - 1);
    if (x >= (longint'(1) << (n - 1))) x -= (longint'(1) << n);
    return 64'(x);
  endfunction

  function automatic exp_t model(input logic [31:0] w, input int g);
    bit rv64, m, a, s, ok, wr, wd;
    int kind;
    logic [2:0] f3;
    logic [6:0] f7;
    exp_t e;
    rv64 = (g == 2); m = (g != 1); a = (g == 2); s = (g == 2);
    f3 = w[14:12]; f7 = w[31:25];
    e = '0; ok = 0; wr = 0; wd = 0; kind = 0;
    case (w[6:2])
      5'b00000: begin ok = (f3 inside {0, 1, 2, 4, 5}) || (rv64 && (f3 inside {3, 6})); e.unit = 2; wr = 1; kind = 1; end
      5'b01000: begin ok = (f3 inside {0, 1, 2}) || (rv64 && f3 == 3); e.unit = 2; kind = 2; end
      5'b00011: begin ok = (f3 inside {0, 1}); e.unit = 7; kind = 1; end
      5'b00100: begin
        wr = 1; kind = 1;
        if (f3 == 1) ok = rv64 ? (w[31:26] == 0) : (f7 == 0);
        else if (f3 == 5) ok = rv64 ? (w[31:26] inside {0, 16}) : (f7 inside {0, 32});
        else ok = 1;
      end
      5'b00110: begin
        wr = 1; wd = 1; kind = 1;
        ok = rv64 && (f3 == 0 || (f3 == 1 && f7 == 0) || (f3 == 5 && (f7 inside {0, 32})));
      end
      5'b00101, 5'b01101: begin ok = 1; wr = 1; kind = 4; end
      5'b01100: begin
        wr = 1;
        if (f7 == 0) ok = 1;
        else if (f7 == 32) ok = (f3 inside {0, 5});
        else if (f7 == 1) begin ok = m; e.unit = (f3 < 4) ? 3 : 4; end
      end
      5'b01110: begin
        wr = 1; wd = 1;
        if (f7 == 0) ok = rv64 && (f3 inside {0, 1, 5});
        else if (f7 == 32) ok = rv64 && (f3 inside {0, 5});
        else if (f7 == 1) begin ok = rv64 && m && (f3 inside {0, 4, 5, 6, 7}); e.unit = (f3 < 4) ? 3 : 4; end
      end
      5'b01011: begin
        wr = 1; e.unit = 5;
        ok = a && (f3 == 2 || (rv64 && f3 == 3)) &&
             (w[31:27] inside {0, 1, 2, 3, 4, 8, 12, 16, 20, 24, 28}) &&
             !(w[31:27] == 2 && w[24:20] != 0);
      end
      5'b11000: begin ok = !(f3 inside {2, 3}); e.unit = 1; kind = 3; end
      5'b11001: begin ok = (f3 == 0); e.unit = 1; wr = 1; kind = 1; end
      5'b11011: begin ok = 1; e.unit = 1; wr = 1; kind = 5; end
      5'b11100: begin
        e.unit = 6; kind = 1;
        if (f3 == 4) ok = 0;
        else if (f3 != 0) begin ok = 1; wr = 1; end
        else ok = (w inside {32'h00000073, 32'h00100073, 32'h30200073, 32'h10500073}) ||
                  (s && (w == 32'h10200073 || (w[31:20] == 12'h104 && w[14:7] == 0)));
      end
      default: ok = 0;
    endcase
    if (w[1:0] != 2'b11) ok = 0;
    if (!ok) begin
      e = '0; e.unit = 6; e.ill = 1;
      return e;
    end
    e.we = wr && (w[11:7] != 0);
    e.word = wd;
    case (kind)
      1: e.imm = sx({20'b0, w[31:20]}, 12);
      2: e.imm = sx({20'b0, w[31:25], w[11:7]}, 12);
      3: e.imm = sx({19'b0, w[31], w[7], w[30:25], w[11:8], 1'b0}, 13);
      4: e.imm = sx({w[31:12], 12'b0}, 32);
      5: e.imm = sx({11'b0, w[31], w[19:12], w[20], w[30:21], 1'b0}, 21);
      default: e.imm = 64'd0;
    endcase
    return e;
  endfunction

  task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s u%0d: got %h, want %h", nm, g, act, exp);
    end
  endtask

  // Transaction model: up to two beats held; the front one is what id_* must show.
  txn_t       q[$];
  logic [15:0] exp_cnt[3];
  bit          sat_req = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      for (int g = 0; g < 3; g++) exp_cnt[g] = 16'd0;
    end else begin
      bit of, inf;
      if (sat_req) exp_cnt[2] = 16'hFFFF;
      of  = (q.size() != 0) && id_rdy;
      inf = vld && (q.size() < 2);
      if (of)
        for (int g = 0; g < 3; g++)
          if (model(q[0].w, g).ill && exp_cnt[g] != 16'hFFFF) exp_cnt[g] = exp_cnt[g] + 16'd1;
      if (flush) q.delete();
      else begin
        if (of) void'(q.pop_front());
        if (inf) q.push_back('{w: instr, pc: pc_in});
      end
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      logic [63:0] mask;
      exp_t e;
      mask = (g == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      chk("if_ready", g, 64'(o_rdy[g]), 64'(q.size() < 2));
      chk("id_valid", g, 64'(o_vld[g]), 64'(q.size() != 0));
      chk("illegal_cnt", g, 64'(o_cnt[g]), 64'(exp_cnt[g]));
      if (q.size() != 0) begin
        e = model(q[0].w, g);
        chk("instr", g, 64'(o_instr[g]), 64'(q[0].w));
        chk("pc", g, o_pc[g], q[0].pc & mask);
        chk("opcode", g, 64'(o_opc[g]), 64'(q[0].w[6:2]));
        chk("func3", g, 64'(o_f3[g]), 64'(q[0].w[14:12]));
        chk("rs1", g, 64'(o_rs1[g]), 64'(q[0].w[19:15]));
        chk("rs2", g, 64'(o_rs2[g]), 64'(q[0].w[24:20]));
        chk("rd", g, 64'(o_rd[g]), 64'(q[0].w[11:7]));
        chk("unit", g, 64'(o_unit[g]), 64'(e.unit));
        chk("imm", g, o_imm[g], e.imm & mask);
        chk("we", g, 64'(o_we[g]), 64'(e.we));
        chk("word", g, 64'(o_word[g]), 64'(e.word));
        chk("illegal", g, 64'(o_ill[g]), 64'(e.ill));
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the beat was accepted.
  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    instr = w; pc_in = pc_next; vld = 1'b1;
    while (!o_rdy[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_chk++; n_err++;
      $display("FAIL send_timeout: instr %h not accepted after %0d cycles", w, n);
    end
    @(negedge clk);
    vld = 1'b0;
    pc_next += 64'd4;
  endtask

  logic [31:0] stream[18] = '{
    32'h00000073, 32'h10200073, 32'h00200073, 32'h20200073, 32'h02009093, 32'h1000A2AF,
    32'h0000000F, 32'h123450B7, 32'hFE208CE3, 32'h0000E083, 32'h0220C0BB, 32'h4010D093,
    32'h00000001, 32'h00000053, 32'h300020F3, 32'h0220F1B3, 32'h0020B423, 32'h10400073};

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", 0, 64'(o_vld[0]), 64'd0);
    chk("rst_ready", 0, 64'(o_rdy[0]), 64'd1);
    chk("rst_instr", 2, 64'(o_instr[2]), 64'h13);
    chk("rst_imm", 2, o_imm[2], 64'd0);
    chk("rst_opcode", 0, 64'(o_opc[0]), 64'd0);
    chk("rst_cnt", 0, 64'(o_cnt[0]), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    send(32'h00500093);
    chk("addi_valid", 0, 64'(o_vld[0]), 64'd1);
    chk("addi_unit", 0, 64'(o_unit[0]), 64'd0);
    chk("addi_rd", 0, 64'(o_rd[0]), 64'd1);
    chk("addi_imm", 0, o_imm[0], 64'd5);
    chk("addi_we", 0, 64'(o_we[0]), 64'd1);
    chk("addi_illegal", 0, 64'(o_ill[0]), 64'd0);

    send(32'h00003083);
    chk("ld_illegal", 0, 64'(o_ill[0]), 64'd1);
    chk("ld_unit", 0, 64'(o_unit[0]), 64'd6);
    chk("ld_we", 0, 64'(o_we[0]), 64'd0);
    chk("ld_rv64_unit", 2, 64'(o_unit[2]), 64'd2);
    @(negedge clk);
    chk("ld_cnt", 0, 64'(o_cnt[0]), 64'd1);
    chk("ld_rv64_cnt", 2, 64'(o_cnt[2]), 64'd0);

    send(32'h022081B3);
    chk("mul_nom_illegal", 1, 64'(o_ill[1]), 64'd1);
    chk("mul_unit", 0, 64'(o_unit[0]), 64'd3);
    chk("mul_rd", 0, 64'(o_rd[0]), 64'd3);
    chk("mul_rs1", 0, 64'(o_rs1[0]), 64'd1);
    chk("mul_rs2", 0, 64'(o_rs2[0]), 64'd2);

    send(32'hFFDFF0EF);
    chk("jal_imm32", 0, o_imm[0], 64'h0000_0000_FFFF_FFFC);
    chk("jal_imm64", 2, o_imm[2], 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk);

    id_rdy = 1'b0;
    fork
      begin
        send(32'h00100113);
        send(32'h002081B3);
        send(32'h0020A423);
      end
      begin
        repeat (3) @(negedge clk);
        chk("stall_ready", 0, 64'(o_rdy[0]), 64'd0);
        chk("stall_hold", 0, 64'(o_instr[0]), 64'h00100113);
        id_rdy = 1'b1;
        @(negedge clk);
        chk("drain_b", 0, 64'(o_instr[0]), 64'h002081B3);
        @(negedge clk);
        chk("drain_c", 0, 64'(o_instr[0]), 64'h0020A423);
      end
    join
    repeat (2) @(negedge clk);

    id_rdy = 1'b0;
    send(32'h00700393);
    send(32'h00800413);
    instr = 32'h00900493; vld = 1'b1; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; vld = 1'b0;
    chk("flush_valid", 0, 64'(o_vld[0]), 64'd0);
    chk("flush_ready", 0, 64'(o_rdy[0]), 64'd1);
    id_rdy = 1'b1;
    instr = 32'h00A00513; vld = 1'b1; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; vld = 1'b0;
    repeat (3) @(negedge clk);
    chk("flush_drop", 0, 64'(o_vld[0]), 64'd0);

    send(32'hFFF0809B);
    chk("addiw_word", 2, 64'(o_word[2]), 64'd1);
    chk("addiw_imm", 2, o_imm[2], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addiw_rv32_illegal", 0, 64'(o_ill[0]), 64'd1);
    @(negedge clk);

    foreach (stream[i]) send(stream[i]);
    repeat (2) @(negedge clk);

    #1;
    force g_dut[2].u_dut.illegal_cnt_q = 16'hFFFF;
    sat_req = 1;
    #1;
    release g_dut[2].u_dut.illegal_cnt_q;
    @(negedge clk);
    sat_req = 0;
    send(32'h00000000);
    @(negedge clk);
    chk("sat_cnt", 2, 64'(o_cnt[2]), 64'hFFFF);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d errors so far", n_err);
    $fatal(1);
  end
endmodule
